// File: rtl/std_fp_smult_arbiter.sv
// ---------------------------------------------------------------------------
// std_fp_smult_arbiter
//
// Purpose:
//   Shares one pipelined signed fixed-point multiplier (std_fp_smult_pipe)
//   among NREQ requesters using round-robin arbitration. The winner's
//   operands are muxed onto the multiplier and mult_go is held until
//   mult_done. The product is then registered, the winner's done is pulsed
//   for one cycle, and a single DRAIN cycle with mult_go low lets the
//   multiplier pipeline and its done flags clear before the next grant.
//
// Handshake (go/done):
//   A requester raises req_go[i] with stable operands and keeps it high
//   until it sees req_done[i]; it drops go in the cycle after the done.
//   req_done is a one-cycle, one-hot pulse issued only in DRAIN, with the
//   product already on req_out. Towards the multiplier the block is the
//   requester: mult_go is held with stable operands until mult_done, and
//   mult_go falls for one cycle afterwards. A requester may abandon a
//   request by dropping go early; it then receives no done.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-low reset
//   req_go     in   [NREQ]        per-requester go
//   req_left   in   [NREQ*WIDTH]  requester i left operand at [i*WIDTH +: WIDTH]
//   req_right  in   [NREQ*WIDTH]  requester i right operand, same packing
//   req_out    out  [WIDTH]       registered product, held until next result
//   req_done   out  [NREQ]        one-hot one-cycle done pulse
//   mult_left  out  [WIDTH]       multiplier left operand (0 when not busy)
//   mult_right out  [WIDTH]       multiplier right operand (0 when not busy)
//   mult_go    out                multiplier go, high throughout BUSY
//   mult_out   in   [WIDTH]       multiplier product
//   mult_done  in                 multiplier done
//   grant      out  [IDX_W]       current / last granted requester
//   busy       out                high in BUSY and DRAIN
//   dbg_state  out  [2]           FSM state (0 IDLE, 1 BUSY, 2 DRAIN)
// ---------------------------------------------------------------------------
module std_fp_smult_arbiter #(
  parameter int WIDTH      = 32,
  parameter int INT_WIDTH  = 16,
  parameter int FRAC_WIDTH = 16,
  parameter int NREQ       = 4,
  localparam int IDX_W     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_go,
  input  logic [NREQ*WIDTH-1:0] req_left,
  input  logic [NREQ*WIDTH-1:0] req_right,
  output logic [WIDTH-1:0]      req_out,
  output logic [NREQ-1:0]       req_done,
  output logic [WIDTH-1:0]      mult_left,
  output logic [WIDTH-1:0]      mult_right,
  output logic                  mult_go,
  input  logic [WIDTH-1:0]      mult_out,
  input  logic                  mult_done,
  output logic [IDX_W-1:0]      grant,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  // Elaboration-time parameter sanity. INT_WIDTH/FRAC_WIDTH only describe
  // the Q format of the shared multiplier; the arbiter never interprets data.
  if (NREQ < 2) begin : g_bad_nreq
    $error("std_fp_smult_arbiter: NREQ must be at least 2");
  end
  if (INT_WIDTH + FRAC_WIDTH != WIDTH) begin : g_bad_qfmt
    $error("std_fp_smult_arbiter: INT_WIDTH + FRAC_WIDTH must equal WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;

  logic [IDX_W-1:0]  r_rr_ptr;
  logic [IDX_W-1:0]  r_grant;
  logic [WIDTH-1:0]  r_req_out;
  logic [NREQ-1:0]   r_req_done;

  logic              w_found;
  logic [IDX_W-1:0]  w_winner;
  logic [IDX_W-1:0]  w_rr_next;
  logic              w_grant_go;
  logic [NREQ-1:0]   w_grant_onehot;
  logic [WIDTH-1:0]  w_sel_left;
  logic [WIDTH-1:0]  w_sel_right;
  logic              w_take_grant;
  logic              w_capture;

  // (base + off) mod NREQ for off in [0, NREQ]; avoids relying on NREQ
  // being a power of two.
  function automatic logic [IDX_W-1:0] idx_add(input logic [IDX_W-1:0] base,
                                               input int               off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return IDX_W'(s);
  endfunction

  // -------------------------------------------------------------------------
  // Round-robin winner: first requester with go set, scanning upward from
  // r_rr_ptr and wrapping. Only consulted in IDLE.
  // -------------------------------------------------------------------------
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_rr_ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && req_go[idx_add(r_rr_ptr, k)]) begin
        w_found  = 1'b1;
        w_winner = idx_add(r_rr_ptr, k);
      end
    end
  end

  // Pointer moves to the slot after the winner so that the winner has
  // lowest priority in the next arbitration round.
  assign w_rr_next = idx_add(w_winner, 1);

  // Operand mux and go of the registered grant.
  assign w_sel_left  = req_left[int'(r_grant)*WIDTH +: WIDTH];
  assign w_sel_right = req_right[int'(r_grant)*WIDTH +: WIDTH];
  assign w_grant_go  = req_go[r_grant];

  always_comb begin
    w_grant_onehot          = '0;
    w_grant_onehot[r_grant] = 1'b1;
  end

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // -------------------------------------------------------------------------
  // FSM next-state and multiplier-side outputs
  // -------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    mult_go      = 1'b0;
    mult_left    = '0;
    mult_right   = '0;
    w_take_grant = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_take_grant = 1'b1;
          w_next_state = S_BUSY;
        end
      end
      S_BUSY: begin
        mult_go    = 1'b1;
        mult_left  = w_sel_left;
        mult_right = w_sel_right;
        // A finished product is delivered even if the requester drops go in
        // the same cycle; otherwise a dropped go abandons the transaction.
        if (mult_done) begin
          w_capture    = 1'b1;
          w_next_state = S_DRAIN;
        end else if (!w_grant_go) begin
          w_next_state = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // mult_go low for this one cycle resets the multiplier's pipeline.
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Grant, pointer, result and done registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_grant    <= '0;
      r_rr_ptr   <= '0;
      r_req_out  <= '0;
      r_req_done <= '0;
    end else begin
      if (w_take_grant) begin
        r_grant  <= w_winner;
        r_rr_ptr <= w_rr_next;
      end
      if (w_capture) begin
        r_req_out <= mult_out;
      end
      // Capture only happens on BUSY->DRAIN, so the pulse lives exactly in
      // DRAIN and is cleared by the DRAIN->IDLE edge.
      r_req_done <= w_capture ? w_grant_onehot : '0;
    end
  end

  assign req_out   = r_req_out;
  assign req_done  = r_req_done;
  assign grant     = r_grant;
  assign busy      = (r_state == S_BUSY) || (r_state == S_DRAIN);
  assign dbg_state = r_state;

endmodule

// File: doc/std_fp_smult_arbiter.md
Name: std_fp_smult_arbiter

Overview:
- Round-robin arbiter that shares one pipelined signed fixed-point multiplier (`std_fp_smult_pipe`) among NREQ requesters.
- Each requester uses the standard go/done handshake.
- The block muxes the winner's operands onto the multiplier and holds `mult_go` until `mult_done`.
- It then registers the product, pulses the winner's done, and inserts one drain cycle so the multiplier pipeline clears before the next grant.

Parameters:
- WIDTH, 32, operand/result width; must match the multiplier.
- INT_WIDTH, 16, integer bits; passed through for documentation only.
- FRAC_WIDTH, 16, fraction bits; passed through for documentation only.
- NREQ, 4, number of requesters, ≥2.
- IDX_W, $clog2(NREQ), localparam; grant index width.

Ports:
- clk  in  1  clock; all flops rising-edge.
- reset  in  1  asynchronous, active-low reset.
- req_go  in  NREQ  per-requester go; held high until that requester's done.
- req_left  in  NREQ*WIDTH  requester i operand at [i*WIDTH +: WIDTH]; stable while go is high.
- req_right  in  NREQ*WIDTH  same packing as req_left.
- req_out  out  WIDTH  registered product; valid in the req_done cycle, held until the next result.
- req_done  out  NREQ  one-hot, one-cycle done pulse to the served requester.
- mult_left  out  WIDTH  operand to multiplier.
- mult_right  out  WIDTH  operand to multiplier.
- mult_go  out  1  go to multiplier.
- mult_out  in  WIDTH  multiplier result.
- mult_done  in  1  multiplier done.
- grant  out  IDX_W  index of current/last granted requester.
- busy  out  1  high in BUSY and DRAIN.

Behaviour:
- Reset (reset=0, async): state=IDLE, rr_ptr=0, grant=0, req_out=0, req_done=0, mult_go=0, mult_left=0, mult_right=0, busy=0. Reset mid-operation abandons the transaction; no done is issued.
- States: IDLE, BUSY, DRAIN.
- IDLE:
  - Winner = first i with req_go[i]=1, searching from rr_ptr upward, modulo NREQ.
  - If a winner exists: at the clock edge grant<=winner, rr_ptr<=(winner+1) mod NREQ, state<=BUSY.
  - Otherwise stay in IDLE.
  - mult_go=0 and mult operands=0.
- BUSY:
  - mult_go=1; mult_left/mult_right = req_left/req_right slice[grant] (combinational mux from registered grant).
  - On mult_done=1: req_out<=mult_out, req_done[grant]<=1 (registered, so it pulses in the next cycle), state<=DRAIN.
  - If req_go[grant]=0 before mult_done (abort): state<=DRAIN, req_out unchanged, no done.
  - If both happen in the same cycle, mult_done wins and the done is still issued.
- DRAIN:
  - Exactly 1 cycle. mult_go=0, which clears the multiplier's internal pipeline and done flags. req_done pulse is visible here.
  - At the edge: req_done<=0, state<=IDLE.
- Requester contract: drops go in the cycle after its done. Because IDLE samples after DRAIN, the served requester is never regranted on a stale go.
- Throughput: 1 IDLE + multiplier latency (3 cycles for `std_fp_smult_pipe`) + 1 DRAIN = 5 cycles per product. No counting of latency is done; the block relies only on mult_done.
- Latency from req_go rising (block idle) to req_done = 5 cycles.
- req_done is never multi-hot and never asserted outside DRAIN.
- Fairness: a continuously requesting requester waits at most NREQ-1 other transactions.
- Arithmetic: none in this block. Products are passed through unmodified; overflow/truncation is the multiplier's.
- mult_done while in IDLE/DRAIN is ignored.

Test Plan:
- Single requester, Q16.16: req 0 left=0x00018000 (1.5), right=0xFFFE0000 (-2.0) -> req_done[0] pulses 5 cycles after go, req_out=0xFFFD0000 (-3.0), grant=0.
- All 4 go at once after reset, req i operands = (i+1).0 × 2.0 -> dones in order 0,1,2,3, each 5 cycles apart; req_out=0x00020000, 0x00040000, 0x00060000, 0x00080000; never two req_done bits high.
- Round-robin wrap: rr_ptr=3 after serving 2; req 0 and req 3 both go -> 3 served before 0.
- Abort: req 1 drops go 1 cycle into BUSY -> no req_done, req_out unchanged, busy low 2 cycles later, next requester served correctly.
- Async reset asserted mid-BUSY (between clk edges) -> all outputs 0 immediately; after release with req 2 go, first grant=2 and product correct.
- mult_done and req_go[grant]=0 in the same cycle -> done still issued with mult_out captured.
